dac_ddr_tx: RTL and testbench
=============================

DAC_DDR_TX -- requirements
Module: dac_ddr_tx

Interface
REQ-001 SHALL have parameter NBITS, 12, sample width per DAC channel.
REQ-002 SHALL have parameter SYNC_CYCLES, 16, number of cycles the DAC sync is held high during a sync sequence.
REQ-003 SHALL have parameter TRAIN_CYCLES, 64, number of cycles the training pattern is sent before RUN.
REQ-004 SHALL have parameter OFFSET_BIN, 0, where 1 means the MSB of every output word is inverted (two's complement to offset binary).
REQ-005 SHALL have port dac_clk, input, 1, the single clock; every register is on its rising edge.
REQ-006 SHALL have port user_rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports user_enable, input, 1 (enable transmitter) and user_sync, input, 1 (resync request, rising-edge sensitive).
REQ-008 SHALL have port user_valid, input, 1, user sample pair valid.
REQ-009 SHALL have port pattern_sel, input, 2, data source select: 0 user, 1 ramp, 2 midscale, 3 training.
REQ-010 SHALL have port cnt_clr, input, 1, synchronous clear of the underflow counter.
REQ-011 SHALL have ports da_0, da_1, db_0, db_1, input, NBITS each, user samples; _0 is the earlier (rising-edge) sample and _1 the later (falling-edge) sample.
REQ-012 SHALL have ports txa_0, txa_1, txb_0, txb_1, output, NBITS each, registered words for the downstream DDR output cells (_0 rising, _1 falling).
REQ-013 SHALL have ports sync_out_0 and sync_out_1, output, 1 each, DAC sync for each DDR phase.
REQ-014 SHALL have port tx_ready, output, 1, high while in RUN.
REQ-015 SHALL have port underflow_cnt, output, 16, saturating count of underflow cycles.

Function
REQ-016 SHALL implement the FSM states IDLE, SYNC, TRAIN and RUN, with one 16-bit down-counter shared between SYNC and TRAIN.
REQ-017 SHALL move from IDLE to SYNC when user_enable=1, loading the counter with SYNC_CYCLES-1.
REQ-018 SHALL, in SYNC, drive sync_out_0 and sync_out_1 high and all tx words to midscale (0 before OFFSET_BIN encoding); when the counter reaches 0 it SHALL move to TRAIN and load the counter with TRAIN_CYCLES-1.
REQ-019 SHALL, in TRAIN, drive the training pattern on both channels (_0 = 1010...b starting at the MSB, _1 = its bitwise complement); when the counter reaches 0 it SHALL move to RUN.
REQ-020 SHALL, in RUN, set tx_ready=1 and select data per pattern_sel.
REQ-021 SHALL, for pattern_sel=0 with user_valid=1, output the registered user samples; with user_valid=0 it SHALL output midscale and count one underflow.
REQ-022 SHALL, for pattern_sel=1, output a ramp with _0=r and _1=r+1 on both channels, where r advances by 2 per cycle modulo 2^NBITS; r SHALL be 0 on RUN entry.
REQ-023 SHALL, for pattern_sel=2, output midscale; for pattern_sel=3, output the training pattern.
REQ-024 SHALL return to IDLE on the next edge when user_enable=0 in any state; this has priority over every other transition.
REQ-025 SHALL treat a user_sync rising edge (registered and edge-detected) seen in TRAIN or RUN as a move to SYNC with the counter reloaded; in IDLE and SYNC it SHALL be ignored.
REQ-026 SHALL add one cycle of latency: outputs at edge n+1 reflect inputs and state at edge n.
REQ-027 SHALL saturate underflow_cnt at 0xFFFF; cnt_clr SHALL zero it, and a clear SHALL win over a simultaneous increment.
REQ-028 SHALL apply OFFSET_BIN encoding to every tx word after source selection.
REQ-029 SHALL, for SYNC_CYCLES=1 or TRAIN_CYCLES=1, stay exactly one cycle in that state.

Reset
REQ-030 SHALL, while user_rst=1, force state IDLE, counter 0, r 0, tx words to midscale encoding, sync_out_* 0, tx_ready 0, underflow_cnt 0, and the user_sync edge register 0.
REQ-031 SHALL, when reset is asserted mid-sequence, abort the sequence immediately; after release, restart from IDLE.

Verification
REQ-032 SHALL cover: reset, then user_enable=1 -> sync_out high for exactly 16 cycles, then 64 cycles with txa_0=0xAAA and txa_1=0x555, then tx_ready=1.
REQ-033 SHALL cover: RUN with pattern_sel=1 -> txa_0 = 0,2,4,...; at 0xFFE,0xFFF the next pair is 0x000,0x001.
REQ-034 SHALL cover: RUN with pattern_sel=0 and user_valid low for 3 cycles, then cnt_clr with user_valid low on the same cycle -> underflow_cnt reads 3, then 0; tx words read 0 while user_valid is low.
REQ-035 SHALL cover: user_sync pulse in RUN -> tx_ready drops and 16 sync cycles plus 64 training cycles follow; a user_sync pulse during SYNC does not lengthen it.
REQ-036 SHALL cover: user_enable dropped mid-TRAIN -> IDLE next cycle with midscale outputs; user_rst asserted mid-RUN -> outputs go to reset values asynchronously.
REQ-037 SHALL cover: OFFSET_BIN=1 with midscale selected -> tx words read 0x800.

Source files
------------

// File: rtl/dac_ddr_tx.sv
// DDR DAC transmit front end: IDLE/SYNC/TRAIN/RUN sequencer, pattern sources,
// optional offset-binary encoding and a saturating underflow counter.
module dac_ddr_tx #(
    parameter int NBITS        = 12,
    parameter int SYNC_CYCLES  = 16,
    parameter int TRAIN_CYCLES = 64,
    parameter int OFFSET_BIN   = 0
) (
    input  logic             dac_clk,
    input  logic             user_rst,
    input  logic             user_enable,
    input  logic             user_sync,
    input  logic             user_valid,
    input  logic [1:0]       pattern_sel,
    input  logic             cnt_clr,
    input  logic [NBITS-1:0] da_0,
    input  logic [NBITS-1:0] da_1,
    input  logic [NBITS-1:0] db_0,
    input  logic [NBITS-1:0] db_1,
    output logic [NBITS-1:0] txa_0,
    output logic [NBITS-1:0] txa_1,
    output logic [NBITS-1:0] txb_0,
    output logic [NBITS-1:0] txb_1,
    output logic             sync_out_0,
    output logic             sync_out_1,
    output logic             tx_ready,
    output logic [15:0]      underflow_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    function automatic logic [NBITS-1:0] f_train_word();
        logic [NBITS-1:0] w;
        w = {NBITS{1'b0}};
        for (int i = 0; i < NBITS; i++) begin
            w[i] = ((NBITS - 1 - i) % 2 == 0);
        end
        return w;
    endfunction

    localparam logic [NBITS-1:0] TRAIN_W   = f_train_word();
    localparam logic [NBITS-1:0] ENC_MASK  = (OFFSET_BIN != 0) ? {1'b1, {(NBITS-1){1'b0}}}
                                                               : {NBITS{1'b0}};
    localparam logic [NBITS-1:0] MID_ENC   = ENC_MASK;
    localparam logic [NBITS-1:0] RAMP_STEP = {{(NBITS-1){1'b0}}, 1'b1} << 1;
    localparam logic [NBITS-1:0] ONE_W     = {{(NBITS-1){1'b0}}, 1'b1};
    localparam logic [15:0]      SYNC_LOAD  = 16'(SYNC_CYCLES - 1);
    localparam logic [15:0]      TRAIN_LOAD = 16'(TRAIN_CYCLES - 1);

    // Midscale is the all-zero two's-complement word, so encoding is a single MSB flip.
    function automatic logic [NBITS-1:0] f_enc(input logic [NBITS-1:0] w);
        return w ^ ENC_MASK;
    endfunction

    state_t           r_state;
    logic [15:0]      r_cnt;
    logic [NBITS-1:0] r_ramp;
    logic             r_sync_d;
    logic [NBITS-1:0] r_txa_0, r_txa_1, r_txb_0, r_txb_1;
    logic             r_sync_out, r_tx_ready;
    logic [15:0]      r_uflow_cnt;

    logic [NBITS-1:0] w_a0, w_a1, w_b0, w_b1;
    logic             w_sync, w_ready, w_uflow, w_sync_rise;

    assign w_sync_rise = user_sync & ~r_sync_d;

    // Source selection for the word pair launched at the next edge.
    always_comb begin
        w_a0    = {NBITS{1'b0}};
        w_a1    = {NBITS{1'b0}};
        w_b0    = {NBITS{1'b0}};
        w_b1    = {NBITS{1'b0}};
        w_sync  = 1'b0;
        w_ready = 1'b0;
        w_uflow = 1'b0;
        case (r_state)
            ST_IDLE: w_sync = 1'b0;
            ST_SYNC: w_sync = 1'b1;
            ST_TRAIN: begin
                w_a0 = TRAIN_W;  w_a1 = ~TRAIN_W;
                w_b0 = TRAIN_W;  w_b1 = ~TRAIN_W;
            end
            ST_RUN: begin
                w_ready = 1'b1;
                case (pattern_sel)
                    2'd0: begin
                        if (user_valid) begin
                            w_a0 = da_0;  w_a1 = da_1;
                            w_b0 = db_0;  w_b1 = db_1;
                        end else begin
                            w_uflow = 1'b1;
                        end
                    end
                    2'd1: begin
                        w_a0 = r_ramp;  w_a1 = r_ramp + ONE_W;
                        w_b0 = r_ramp;  w_b1 = r_ramp + ONE_W;
                    end
                    2'd2: w_uflow = 1'b0;
                    2'd3: begin
                        w_a0 = TRAIN_W;  w_a1 = ~TRAIN_W;
                        w_b0 = TRAIN_W;  w_b1 = ~TRAIN_W;
                    end
                    default: w_uflow = 1'b0;
                endcase
            end
            default: w_sync = 1'b0;
        endcase
    end

    // Sequencer, shared SYNC/TRAIN down-counter, ramp generator and sync edge register.
    always_ff @(posedge dac_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 16'd0;
            r_ramp   <= {NBITS{1'b0}};
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= user_sync;
            if (!user_enable) begin
                r_state <= ST_IDLE;
                r_cnt   <= 16'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SYNC;
                        r_cnt   <= SYNC_LOAD;
                    end
                    ST_SYNC: begin
                        if (r_cnt == 16'd0) begin
                            r_state <= ST_TRAIN;
                            r_cnt   <= TRAIN_LOAD;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    ST_TRAIN: begin
                        if (w_sync_rise) begin
                            r_state <= ST_SYNC;
                            r_cnt   <= SYNC_LOAD;
                        end else if (r_cnt == 16'd0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    ST_RUN: begin
                        if (w_sync_rise) begin
                            r_state <= ST_SYNC;
                            r_cnt   <= SYNC_LOAD;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 16'd0;
                    end
                endcase
            end
            // The ramp is parked at zero outside RUN so it always restarts from 0.
            if (r_state == ST_RUN) begin
                if (pattern_sel == 2'd1) begin
                    r_ramp <= r_ramp + RAMP_STEP;
                end
            end else begin
                r_ramp <= {NBITS{1'b0}};
            end
        end
    end

    // Output word, sync and ready registers feeding the DDR cells.
    always_ff @(posedge dac_clk or posedge user_rst) begin
        if (user_rst) begin
            r_txa_0    <= MID_ENC;
            r_txa_1    <= MID_ENC;
            r_txb_0    <= MID_ENC;
            r_txb_1    <= MID_ENC;
            r_sync_out <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_txa_0    <= f_enc(w_a0);
            r_txa_1    <= f_enc(w_a1);
            r_txb_0    <= f_enc(w_b0);
            r_txb_1    <= f_enc(w_b1);
            r_sync_out <= w_sync;
            r_tx_ready <= w_ready;
        end
    end

    // Saturating underflow counter; a clear beats a same-cycle increment.
    always_ff @(posedge dac_clk or posedge user_rst) begin
        if (user_rst) begin
            r_uflow_cnt <= 16'd0;
        end else if (cnt_clr) begin
            r_uflow_cnt <= 16'd0;
        end else if (w_uflow && (r_uflow_cnt != 16'hFFFF)) begin
            r_uflow_cnt <= r_uflow_cnt + 16'd1;
        end else begin
            r_uflow_cnt <= r_uflow_cnt;
        end
    end

    assign txa_0         = r_txa_0;
    assign txa_1         = r_txa_1;
    assign txb_0         = r_txb_0;
    assign txb_1         = r_txb_1;
    assign sync_out_0    = r_sync_out;
    assign sync_out_1    = r_sync_out;
    assign tx_ready      = r_tx_ready;
    assign underflow_cnt = r_uflow_cnt;

endmodule

// File: tb/tb_dac_ddr_tx.sv
// Directed/randomised bench for dac_ddr_tx: two instances (default and short
// sequences with offset binary) checked every cycle against a phase/age model.
module tb_dac_ddr_tx;

    logic        dac_clk;
    logic        user_rst, user_enable, user_sync, user_valid, cnt_clr;
    logic [1:0]  pattern_sel;
    logic [11:0] da_0, da_1, db_0, db_1;

    logic [11:0] p0_txa_0, p0_txa_1, p0_txb_0, p0_txb_1;
    logic [11:0] p1_txa_0, p1_txa_1, p1_txb_0, p1_txb_1;
    logic        p0_s0, p0_s1, p0_rdy, p1_s0, p1_s1, p1_rdy;
    logic [15:0] p0_uc, p1_uc;

    dac_ddr_tx u_dut0 (
        .dac_clk(dac_clk), .user_rst(user_rst), .user_enable(user_enable),
        .user_sync(user_sync), .user_valid(user_valid), .pattern_sel(pattern_sel),
        .cnt_clr(cnt_clr), .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
        .txa_0(p0_txa_0), .txa_1(p0_txa_1), .txb_0(p0_txb_0), .txb_1(p0_txb_1),
        .sync_out_0(p0_s0), .sync_out_1(p0_s1), .tx_ready(p0_rdy), .underflow_cnt(p0_uc)
    );

    dac_ddr_tx #(.NBITS(12), .SYNC_CYCLES(1), .TRAIN_CYCLES(1), .OFFSET_BIN(1)) u_dut1 (
        .dac_clk(dac_clk), .user_rst(user_rst), .user_enable(user_enable),
        .user_sync(user_sync), .user_valid(user_valid), .pattern_sel(pattern_sel),
        .cnt_clr(cnt_clr), .da_0(da_0), .da_1(da_1), .db_0(db_0), .db_1(db_1),
        .txa_0(p1_txa_0), .txa_1(p1_txa_1), .txb_0(p1_txb_0), .txb_1(p1_txb_1),
        .sync_out_0(p1_s0), .sync_out_1(p1_s1), .tx_ready(p1_rdy), .underflow_cnt(p1_uc)
    );

    initial dac_clk = 1'b0;
    always #5 dac_clk = ~dac_clk;

    localparam int PH_IDLE = 0, PH_SYNC = 1, PH_TRAIN = 2, PH_RUN = 3;
    int P_SYNC [2] = '{16, 1};
    int P_TRAIN[2] = '{64, 1};
    bit P_OFF  [2] = '{1'b0, 1'b1};

    int          m_phase[2], m_age[2], m_r[2], m_uc[2];
    bit          m_ps[2];
    logic [11:0] e_tx[2][4];
    logic        e_sync[2], e_rdy[2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] menc(input int d, input int v);
        logic [11:0] w;
        w = 12'(v);
        return P_OFF[d] ? (w ^ 12'h800) : w;
    endfunction

    task automatic model_reset(input int d);
        m_phase[d] = PH_IDLE; m_age[d] = 0; m_r[d] = 0; m_uc[d] = 0; m_ps[d] = 1'b0;
        for (int k = 0; k < 4; k++) e_tx[d][k] = menc(d, 0);
        e_sync[d] = 1'b0; e_rdy[d] = 1'b0;
    endtask

    // Outputs after an edge follow the phase held before it; then the phase advances.
    task automatic model_edge();
        int raw[4];
        bit rise, under;
        for (int d = 0; d < 2; d++) begin
            if (user_rst) begin
                model_reset(d);
            end else begin
                rise = user_sync && !m_ps[d];
                m_ps[d] = user_sync;
                raw = '{0, 0, 0, 0};
                under = 1'b0;
                e_sync[d] = (m_phase[d] == PH_SYNC);
                e_rdy[d]  = (m_phase[d] == PH_RUN);
                if (m_phase[d] == PH_TRAIN) raw = '{'hAAA, 'h555, 'hAAA, 'h555};
                if (m_phase[d] == PH_RUN) begin
                    case (pattern_sel)
                        2'd0: if (user_valid) raw = '{int'(da_0), int'(da_1), int'(db_0), int'(db_1)};
                              else under = 1'b1;
                        2'd1: begin
                            raw = '{m_r[d], m_r[d] + 1, m_r[d], m_r[d] + 1};
                            m_r[d] = (m_r[d] + 2) % 4096;
                        end
                        2'd3: raw = '{'hAAA, 'h555, 'hAAA, 'h555};
                        default: raw = '{0, 0, 0, 0};
                    endcase
                end
                for (int k = 0; k < 4; k++) e_tx[d][k] = menc(d, raw[k]);
                if (cnt_clr) m_uc[d] = 0;
                else if (under && m_uc[d] < 65535) m_uc[d]++;
                if (!user_enable) begin
                    m_phase[d] = PH_IDLE;
                end else if (m_phase[d] == PH_IDLE) begin
                    m_phase[d] = PH_SYNC; m_age[d] = 0;
                end else if (m_phase[d] == PH_SYNC) begin
                    m_age[d]++;
                    if (m_age[d] >= P_SYNC[d]) begin m_phase[d] = PH_TRAIN; m_age[d] = 0; end
                end else if (rise) begin
                    m_phase[d] = PH_SYNC; m_age[d] = 0;
                end else if (m_phase[d] == PH_TRAIN) begin
                    m_age[d]++;
                    if (m_age[d] >= P_TRAIN[d]) begin m_phase[d] = PH_RUN; m_r[d] = 0; end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("d0_txa_0", p0_txa_0, e_tx[0][0]); chk("d0_txa_1", p0_txa_1, e_tx[0][1]);
        chk("d0_txb_0", p0_txb_0, e_tx[0][2]); chk("d0_txb_1", p0_txb_1, e_tx[0][3]);
        chk("d0_sync0", p0_s0, e_sync[0]);     chk("d0_sync1", p0_s1, e_sync[0]);
        chk("d0_ready", p0_rdy, e_rdy[0]);     chk("d0_uflow", p0_uc, m_uc[0]);
        chk("d1_txa_0", p1_txa_0, e_tx[1][0]); chk("d1_txa_1", p1_txa_1, e_tx[1][1]);
        chk("d1_txb_0", p1_txb_0, e_tx[1][2]); chk("d1_txb_1", p1_txb_1, e_tx[1][3]);
        chk("d1_sync0", p1_s0, e_sync[1]);     chk("d1_sync1", p1_s1, e_sync[1]);
        chk("d1_ready", p1_rdy, e_rdy[1]);     chk("d1_uflow", p1_uc, m_uc[1]);
    endtask

    task automatic step();
        @(posedge dac_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rand_data();
        da_0 = 12'($urandom); da_1 = 12'($urandom);
        db_0 = 12'($urandom); db_1 = 12'($urandom);
    endtask

    initial begin
        int sync_hi, train_n, ready_lo, wrap_n;
        bit back;
        logic [11:0] prev;

        user_rst = 1'b1; user_enable = 1'b0; user_sync = 1'b0; user_valid = 1'b0;
        cnt_clr = 1'b0; pattern_sel = 2'd2;
        da_0 = 12'h0; da_1 = 12'h0; db_0 = 12'h0; db_1 = 12'h0;
        #1;
        model_reset(0); model_reset(1);
        compare_all();
        chk("rst_d1_mid_enc", p1_txa_0, 12'h800);
        repeat (3) step();
        user_rst = 1'b0;

        // Bring-up: 16 sync cycles, 64 training cycles, then RUN on midscale.
        user_enable = 1'b1;
        sync_hi = 0; train_n = 0;
        for (int i = 0; i < 100; i++) begin
            rand_data();
            step();
            if (p0_s0) sync_hi++;
            if (p0_txa_0 == 12'hAAA && p0_txa_1 == 12'h555) train_n++;
        end
        chk("bringup_sync_len", sync_hi, 16);
        chk("bringup_train_len", train_n, 64);
        chk("bringup_ready", p0_rdy, 1'b1);
        chk("offset_mid_800", p1_txa_0, 12'h800);

        // Ramp through the wrap point.
        pattern_sel = 2'd1; prev = 12'h000; wrap_n = 0;
        for (int i = 0; i < 2100; i++) begin
            step();
            if (prev == 12'hFFE) begin
                chk("ramp_wrap_a0", p0_txa_0, 12'h000);
                chk("ramp_wrap_a1", p0_txa_1, 12'h001);
                wrap_n++;
            end
            prev = p0_txa_0;
        end
        chk("ramp_wrap_seen", wrap_n, 1);

        // User data with random valid gaps, then directed underflow and clear.
        pattern_sel = 2'd0;
        for (int i = 0; i < 40; i++) begin
            rand_data();
            user_valid = 1'($urandom_range(0, 1));
            cnt_clr = ($urandom_range(0, 9) == 0);
            step();
        end
        cnt_clr = 1'b1; user_valid = 1'b1; step();
        cnt_clr = 1'b0; user_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
            chk("uflow_word_zero", p0_txa_0, 12'h000);
        end
        chk("uflow_cnt_3", p0_uc, 16'd3);
        cnt_clr = 1'b1; step();
        chk("uflow_clr_wins", p0_uc, 16'd0);
        cnt_clr = 1'b0; user_valid = 1'b1;

        // Resync from RUN with a second pulse inside SYNC.
        user_sync = 1'b1; step();
        sync_hi = 0; ready_lo = 0; back = 1'b0;
        for (int i = 0; i < 200 && !back; i++) begin
            user_sync = (i == 5);
            rand_data();
            step();
            if (p0_s0) sync_hi++;
            if (!p0_rdy) ready_lo++;
            else if (ready_lo > 0) back = 1'b1;
        end
        user_sync = 1'b0;
        chk("resync_ready_back", back, 1'b1);
        chk("resync_sync_len", sync_hi, 16);
        chk("resync_ready_low", ready_lo, 80);

        // Drop enable in the middle of training.
        user_sync = 1'b1; step(); user_sync = 1'b0;
        repeat (26) step();
        chk("mid_train_pattern", p0_txa_0, 12'hAAA);
        user_enable = 1'b0; step(); step();
        chk("disable_mid", p0_txa_0, 12'h000);
        chk("disable_ready", p0_rdy, 1'b0);

        // Asynchronous reset in RUN.
        user_enable = 1'b1; pattern_sel = 2'd1;
        repeat (90) step();
        #2 user_rst = 1'b1;
        #1;
        model_reset(0); model_reset(1);
        chk("async_rst_ready", p0_rdy, 1'b0);
        chk("async_rst_word", p0_txa_0, 12'h000);
        chk("async_rst_d1_word", p1_txa_1, 12'h800);
        compare_all();
        repeat (2) step();
        user_rst = 1'b0;

        // Randomised run: patterns, data, valid, clears, sync pulses, enable drops.
        for (int i = 0; i < 400; i++) begin
            rand_data();
            pattern_sel = 2'($urandom_range(0, 3));
            user_valid  = 1'($urandom_range(0, 1));
            cnt_clr     = ($urandom_range(0, 19) == 0);
            user_sync   = ($urandom_range(0, 29) == 0);
            user_enable = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
